// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// MM:SS BCD stopwatch driven by the slow clk_out square wave of clk_prescaler.
// tick_in is sampled in the clk_in domain and only its rising edges count.
// Nothing in here is clocked by tick_in.
//
// Ports
//   clk_in      system clock (same clock as clk_prescaler)
//   rst_n       asynchronous active-low reset
//   tick_in     prescaler clk_out, synchronous to clk_in
//   start_stop  single-cycle pulse, toggles IDLE/RUN
//   clear       level, zeroes digits and tick divider at the next edge
//   sec_ones    BCD seconds units (0..9)
//   sec_tens    BCD seconds tens  (0..5)
//   min_ones    BCD minutes units (0..9)
//   min_tens    BCD minutes tens  (0..9)
//   running     1 while in RUN; this is the run-state register itself
//   wrap        one-cycle pulse on MAX_MIN:59 -> 00:00
//
// Control interface: start_stop and clear have no handshake. A start_stop
// pulse is consumed at the edge it is seen; clear acts on every edge while
// it is high. A tick rise at the same edge as start_stop uses the old state.
// -----------------------------------------------------------------------------
module stopwatch_counter #(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned MAX_MIN       = 59
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  localparam logic [7:0] DIV_LAST  = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0] MAX_MIN_V = 8'(MAX_MIN);

  run_state_t state_q, state_d;
  logic       tick_q;
  logic [7:0] div_q, div_d;
  logic [3:0] sec_ones_d, sec_tens_d, min_ones_d, min_tens_d;
  logic       wrap_d;
  logic       rise;
  logic [7:0] min_value;
  logic       at_max;

  // Rollover is decided on the full minutes value, so MAX_MIN like 15 wraps
  // at 15:59 rather than at any per-digit limit.
  assign min_value = ({4'd0, min_tens} * 8'd10) + {4'd0, min_ones};
  assign at_max    = (min_value == MAX_MIN_V) && (sec_tens == 4'd5) &&
                     (sec_ones == 4'd9);

  assign rise    = tick_in & ~tick_q;
  assign running = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sec_ones_d = sec_ones;
    sec_tens_d = sec_tens;
    min_ones_d = min_ones;
    min_tens_d = min_tens;
    wrap_d     = 1'b0;

    if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (clear) begin
      div_d      = 8'd0;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if ((state_q == RUN) && rise) begin
      if (div_q == DIV_LAST) begin
        div_d = 8'd0;
        if (at_max) begin
          sec_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          min_ones_d = 4'd0;
          min_tens_d = 4'd0;
          wrap_d     = 1'b1;
        end else if (sec_ones != 4'd9) begin
          sec_ones_d = sec_ones + 4'd1;
        end else begin
          sec_ones_d = 4'd0;
          if (sec_tens != 4'd5) begin
            sec_tens_d = sec_tens + 4'd1;
          end else begin
            sec_tens_d = 4'd0;
            if (min_ones != 4'd9) begin
              min_ones_d = min_ones + 4'd1;
            end else begin
              min_ones_d = 4'd0;
              min_tens_d = min_tens + 4'd1;
            end
          end
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  // tick_q resets high so a tick_in already high at reset release is not
  // mistaken for a fresh edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tick_q   <= 1'b1;
      div_q    <= 8'd0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      wrap     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_in;
      div_q    <= div_d;
      sec_ones <= sec_ones_d;
      sec_tens <= sec_tens_d;
      min_ones <= min_ones_d;
      min_tens <= min_tens_d;
      wrap     <= wrap_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Three instances share one stimulus stream:
//   0: TICKS_PER_SEC=1, MAX_MIN=59
//   1: TICKS_PER_SEC=4, MAX_MIN=59
//   2: TICKS_PER_SEC=1, MAX_MIN=1
// The reference keeps elapsed time as a plain count of seconds and derives
// the digits with division, checked every cycle, plus constant checks at the
// scenario points.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic tick_in    = 1'b1;
  logic start_stop = 1'b0;
  logic clear      = 1'b0;

  always #5 clk_in = ~clk_in;

  logic [3:0] so [N];
  logic [3:0] st [N];
  logic [3:0] mo [N];
  logic [3:0] mt [N];
  logic       run [N];
  logic       wr  [N];

  stopwatch_counter #(.TICKS_PER_SEC(1), .MAX_MIN(59)) u_a (
    .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in),
    .start_stop(start_stop), .clear(clear),
    .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
    .running(run[0]), .wrap(wr[0])
  );

  stopwatch_counter #(.TICKS_PER_SEC(4), .MAX_MIN(59)) u_b (
    .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in),
    .start_stop(start_stop), .clear(clear),
    .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
    .running(run[1]), .wrap(wr[1])
  );

  stopwatch_counter #(.TICKS_PER_SEC(1), .MAX_MIN(1)) u_c (
    .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in),
    .start_stop(start_stop), .clear(clear),
    .sec_ones(so[2]), .sec_tens(st[2]), .min_ones(mo[2]), .min_tens(mt[2]),
    .running(run[2]), .wrap(wr[2])
  );

  // ---------------- reference model ----------------
  int tps [N] = '{1, 4, 1};
  int mm  [N] = '{59, 59, 1};
  int m_secs [N];
  int m_div  [N];
  bit m_run  [N];
  bit m_wrap [N];
  bit m_tq;
  logic cur_tick;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_secs[i] = 0;
      m_div[i]  = 0;
      m_run[i]  = 1'b0;
      m_wrap[i] = 1'b0;
    end
    m_tq = 1'b1;
  endtask

  task automatic model_step(input logic ti, input logic ss, input logic cl);
    bit r;
    r = ti && !m_tq;
    for (int i = 0; i < N; i++) begin
      m_wrap[i] = 1'b0;
      if (cl) begin
        m_secs[i] = 0;
        m_div[i]  = 0;
      end else if (m_run[i] && r) begin
        if (m_div[i] == tps[i] - 1) begin
          m_div[i] = 0;
          m_secs[i]++;
          if (m_secs[i] == (mm[i] + 1) * 60) begin
            m_secs[i] = 0;
            m_wrap[i] = 1'b1;
          end
        end else begin
          m_div[i]++;
        end
      end
      if (ss) m_run[i] = !m_run[i];
    end
    m_tq = ti;
  endtask

  function automatic logic [15:0] digits(input int i);
    return {mt[i], mo[i], st[i], so[i]};
  endfunction

  task automatic check_all(input string tag);
    int m, s;
    logic [17:0] exp;
    for (int i = 0; i < N; i++) begin
      m   = m_secs[i] / 60;
      s   = m_secs[i] % 60;
      exp = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), m_run[i], m_wrap[i]};
      check($sformatf("%s[%0d]", tag, i),
            32'({digits(i), run[i], wr[i]}), 32'(exp));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered away from a posedge; returns 1 time unit after the posedge.
  task automatic cycle(input logic ti, input logic ss, input logic cl);
    tick_in    = ti;
    start_stop = ss;
    clear      = cl;
    cur_tick   = ti;
    @(posedge clk_in);
    #1;
    model_step(ti, ss, cl);
    check_all("cyc");
  endtask

  task automatic rise_tick();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic rises(input int n);
    for (int k = 0; k < n; k++) rise_tick();
  endtask

  task automatic pulse_ss();
    cycle(cur_tick, 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    tick_in    = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
    cur_tick   = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    model_reset();
    cur_tick = 1'b1;
    #2;
    apply_reset();

    // tick_in high across release, 10 tick periods while idle
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
    end
    check("idle_digits", 32'(digits(0)), 32'h0000);
    check("idle_run", 32'(run[0]), 32'd0);

    // reset with tick high then start: held-high tick must not count
    apply_reset();
    pulse_ss();
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    check("no_spurious", 32'(digits(0)), 32'h0000);

    // 75 seconds at one tick per second
    rises(75);
    check("t75_digits", 32'(digits(0)), 32'h0115);
    check("t75_run", 32'(run[0]), 32'd1);

    // four ticks per second with pause
    apply_reset();
    pulse_ss();
    rises(6);
    check("b6_digits", 32'(digits(1)), 32'h0001);
    pulse_ss();
    rises(5);
    check("b_pause_digits", 32'(digits(1)), 32'h0001);
    check("b_pause_run", 32'(run[1]), 32'd0);
    pulse_ss();
    rises(2);
    check("b_resume_digits", 32'(digits(1)), 32'h0002);

    // MAX_MIN=1 rollover
    apply_reset();
    pulse_ss();
    rises(119);
    check("c_159", 32'(digits(2)), 32'h0159);
    check("c_pre_wrap", 32'(wr[2]), 32'd0);
    rise_tick();
    check("c_wrap_digits", 32'(digits(2)), 32'h0000);
    check("c_wrap_pulse", 32'(wr[2]), 32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    check("c_wrap_clear", 32'(wr[2]), 32'd0);

    // clear coinciding with a counting rise
    apply_reset();
    pulse_ss();
    rises(42);
    check("a_42", 32'(digits(0)), 32'h0042);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check("clr_digits", 32'(digits(0)), 32'h0000);
    check("clr_run", 32'(run[0]), 32'd1);
    rise_tick();
    check("clr_next", 32'(digits(0)), 32'h0001);

    // asynchronous reset between edges
    apply_reset();
    pulse_ss();
    rises(207);
    check("a_327", 32'(digits(0)), 32'h0327);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_digits", 32'(digits(0)), 32'h0000);
    check("async_run", 32'(run[0]), 32'd0);
    apply_reset();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      else cycle(1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
